ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  Multi-master AHB arbiter in front of the shared address/control mux. Takes bus requests and lock
//  requests from NO_OF_MASTERS masters and grants the bus one master at a time, round-robin.
//  Grants change only at burst boundaries. Drives hmaster, which selects the master in the
//  downstream address/data mux, and drives hmastlock, which the slaves consume.
// PARAMETERS
//  NO_OF_MASTERS  3   number of requesting masters (from AhbGlobalPackage)
//  HMASTER_WIDTH  (NO_OF_MASTERS==1)?1:$clog2(NO_OF_MASTERS)   width of the master ID
//  DEFAULT_MASTER 0   master that is granted when no master is requesting
// PORTS
//  hclk       in   1              bus clock; all state changes on rising edge
//  hresetn    in   1              asynchronous, active-low reset
//  hbusreq    in   NO_OF_MASTERS  per-master bus request
//  hlock      in   NO_OF_MASTERS  per-master locked-sequence request
//  htrans     in   2              ahbTransferEnum of the current address-phase owner (muxed)
//  hburst     in   3              ahbBurstEnum of the current address-phase owner (muxed)
//  hready     in   1              combined transfer completion
//  hresp      in   1              ahbRespEnum (OKAY/ERROR)
//  hgrant     out  NO_OF_MASTERS  one-hot grant
//  hmaster    out  HMASTER_WIDTH  ID of the address-phase owner
//  hmastlock  out  1              current address phase is part of a locked sequence
// BEHAVIOUR
//  Reset (async): hgrant=onehot(DEFAULT_MASTER), hmaster=DEFAULT_MASTER, hmastlock=0,
//    beatCnt=0, state=ARB_IDLE, rrPtr=DEFAULT_MASTER.
//  States (ahbArbStateEnum):
//    ARB_IDLE   no burst in progress
//    ARB_BURST  fixed-length or INCR burst in progress
//    ARB_LOCKED locked sequence in progress
//  Beat counting: one beat = cycle with hready=1 and htrans in {NONSEQ,SEQ}.
//    NONSEQ loads beatCnt=1; SEQ increments it; BUSY and hready=0 hold it.
//    Beat limit = burstBeats(hburst): SINGLE=1, *4=4, *8=8, *16=16, INCR=0 (unbounded).
//  Arbitration point (AP): hready=1 AND any one of:
//    - htrans==IDLE
//    - beat limit nonzero and this beat is the last beat
//    - hburst==INCR and htrans==NONSEQ and the granted master has dropped hbusreq
//    - previous cycle had hresp=ERROR with hready=0 (early termination)
//  At an AP:
//    - If the granted master has hlock=1, it keeps the grant; go to or stay in ARB_LOCKED.
//    - Otherwise the grant goes to the first requesting master, searching from rrPtr+1 mod N.
//    - If no master is requesting, the grant goes to DEFAULT_MASTER.
//    - The grant is registered: hgrant changes on the clock edge after the AP, so latency is
//      1 cycle from a request seen at an AP.
//    - rrPtr updates to the newly granted index.
//  Outside an AP, hgrant holds even if hbusreq of the owner drops.
//  hmaster/hmastlock update on the first edge with hready=1 after the hgrant change; they then
//    equal the granted index and that master's hlock. They hold while hready=0.
//  Locked sequence: ARB_LOCKED exits at the first AP where the owner's hlock=0. hmastlock then
//    falls with the next hmaster update.
//  Simultaneous requests at reset release: the round-robin search starts at DEFAULT_MASTER+1.
//  Exactly one bit of hgrant is set at all times. Idle cycles never change the grant except at
//    an AP.
//  Reset mid-burst: all outputs go to reset values immediately; the burst is abandoned.
// STRUCTURE
//  AhbGlobalPackage gains:
//    - ahbArbStateEnum {ARB_IDLE, ARB_BURST, ARB_LOCKED}
//    - function burstBeats(ahbBurstEnum) returning int
//  Sub-module ahb_rr_priority_picker: combinational; inputs req[N] and ptr; output one-hot
//    grant and its index.
// TESTING
//  Reset: hresetn=0 mid-burst -> hgrant=3'b001, hmaster=0, hmastlock=0 in the same cycle.
//  Round-robin: hbusreq=3'b111, SINGLE NONSEQ every cycle -> grants rotate 1,2,0,1,... one per
//    AP, with hmaster following 1 cycle later.
//  INCR4, master 1 owns the bus, master 2 requests at beat 2 -> hgrant stays 3'b010 until
//    beat 4 completes; hgrant=3'b100 on the next edge.
//  Wait states: INCR8 with hready=0 for 3 cycles on beat 5 -> beatCnt holds at 5 and the AP
//    occurs only on beat 8.
//  Lock: master 2 hlock=1 across two INCR4 bursts while masters 0 and 1 request -> no grant
//    change and hmastlock=1 throughout; it drops after the first AP with hlock=0.
//  ERROR: WRAP8 beat 3, hresp=ERROR for 2 cycles (hready 0 then 1), master 0 requesting ->
//    hgrant=3'b001 on the following edge.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ahb_bus_arbiter_pkg
// Purpose  : Shared AHB types for the bus arbiter. Defines the transfer, burst,
//            response and arbiter-state encodings, the default master count,
//            and a helper that maps a burst type to its beat count.
// Revision : 1.0  initial release
// ============================================================================
package ahb_bus_arbiter_pkg;

  localparam int unsigned c_ahb_no_of_masters = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_trans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } ahb_burst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } ahb_resp_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BURST  = 2'b01,
    ARB_LOCKED = 2'b10
  } ahb_arb_state_e;

  // Number of beats in a burst; 0 means unbounded (INCR).
  function automatic int burst_beats(input ahb_burst_e burst);
    case (burst)
      BURST_SINGLE:               return 1;
      BURST_WRAP4,  BURST_INCR4:  return 4;
      BURST_WRAP8,  BURST_INCR8:  return 8;
      BURST_WRAP16, BURST_INCR16: return 16;
      default:                    return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : ahb_rr_priority_picker
// Purpose  : Combinational round-robin picker. Finds the first set request
//            bit searching upward from ptr+1 (mod N), wrapping to ptr itself
//            last.
// Ports    : req   in  N  request vector
//            ptr   in  W  index of the most recent winner
//            grant out N  one-hot winner (all zero when valid=0)
//            idx   out W  index of the winner
//            valid out 1  at least one request is set
// Revision : 1.0  initial release
// ============================================================================
module ahb_rr_priority_picker #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);

  // One extra bit so ptr+i (at most 2N-1) never overflows before the wrap.
  localparam int unsigned c_cw = W + 1;

  logic [c_cw-1:0] w_cand;

  always_comb begin
    grant  = '0;
    idx    = '0;
    valid  = 1'b0;
    w_cand = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_cand = {1'b0, ptr} + c_cw'(i);
      if (w_cand >= c_cw'(N)) begin
        w_cand = w_cand - c_cw'(N);
      end
      if (!valid && req[w_cand[W-1:0]]) begin
        valid = 1'b1;
        idx   = w_cand[W-1:0];
      end
    end
    if (valid) begin
      grant[idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_arbiter
// Purpose  : Round-robin AHB bus arbiter. Grants change only at arbitration
//            points (burst boundaries, IDLE transfers, INCR release, or after
//            an ERROR response); a locked owner keeps the bus.
// Ports    : hclk      in  1  bus clock
//            hresetn   in  1  asynchronous active-low reset
//            hbusreq   in  N  per-master bus request
//            hlock     in  N  per-master locked-sequence request
//            htrans    in  2  transfer type of the address-phase owner
//            hburst    in  3  burst type of the address-phase owner
//            hready    in  1  transfer completion
//            hresp     in  1  OKAY/ERROR
//            hgrant    out N  registered one-hot grant
//            hmaster   out W  address-phase owner ID
//            hmastlock out 1  address phase belongs to a locked sequence
// Revision : 1.0  initial release
// ============================================================================
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int unsigned NO_OF_MASTERS  = c_ahb_no_of_masters,
  parameter int unsigned HMASTER_WIDTH  = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS),
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NO_OF_MASTERS-1:0] hbusreq,
  input  logic [NO_OF_MASTERS-1:0] hlock,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic                     hready,
  input  logic                     hresp,
  output logic [NO_OF_MASTERS-1:0] hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic                     hmastlock
);

  localparam logic [HMASTER_WIDTH-1:0] c_default_idx   = HMASTER_WIDTH'(DEFAULT_MASTER);
  localparam logic [NO_OF_MASTERS-1:0] c_default_grant = NO_OF_MASTERS'(1) << DEFAULT_MASTER;

  ahb_arb_state_e           r_state, w_next_state;
  // The round-robin pointer always equals the granted index, so one register
  // serves both roles.
  logic [HMASTER_WIDTH-1:0] r_grant_idx, w_next_idx;
  logic [NO_OF_MASTERS-1:0] r_hgrant, w_next_grant;
  logic [4:0]               r_beat_cnt;
  logic                     r_err_prev;
  logic [HMASTER_WIDTH-1:0] r_hmaster;
  logic                     r_hmastlock;

  logic                     w_beat;
  logic [4:0]               w_beat_num;
  logic [4:0]               w_limit;
  logic                     w_last;
  logic                     w_incr_release;
  logic                     w_ap;
  logic [NO_OF_MASTERS-1:0] w_pick_grant;
  logic [HMASTER_WIDTH-1:0] w_pick_idx;
  logic                     w_pick_valid;

  ahb_rr_priority_picker #(
    .N (NO_OF_MASTERS),
    .W (HMASTER_WIDTH)
  ) u_picker (
    .req   (hbusreq),
    .ptr   (r_grant_idx),
    .grant (w_pick_grant),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  assign w_beat     = hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  // Ordinal of the beat completing this cycle (meaningful only when w_beat).
  assign w_beat_num = (htrans == HTRANS_NONSEQ) ? 5'd1 : r_beat_cnt + 5'd1;
  assign w_limit    = 5'(burst_beats(ahb_burst_e'(hburst)));
  assign w_last     = w_beat && (w_limit != 5'd0) && (w_beat_num == w_limit);
  assign w_incr_release = (hburst == BURST_INCR) && (htrans == HTRANS_NONSEQ)
                          && !hbusreq[r_grant_idx];
  // r_err_prev marks the first (hready=0) cycle of a two-cycle ERROR response;
  // the bus is re-arbitrated as the response completes.
  assign w_ap = hready && ((htrans == HTRANS_IDLE) || w_last || w_incr_release || r_err_prev);

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_grant_idx;
    w_next_grant = r_hgrant;
    if (w_ap) begin
      if (hlock[r_grant_idx]) begin
        w_next_state = ARB_LOCKED;
      end else begin
        w_next_state = ARB_IDLE;
        if (w_pick_valid) begin
          w_next_idx   = w_pick_idx;
          w_next_grant = w_pick_grant;
        end else begin
          w_next_idx   = c_default_idx;
          w_next_grant = c_default_grant;
        end
      end
    end else if (r_state == ARB_IDLE && w_beat) begin
      w_next_state = ARB_BURST;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= ARB_IDLE;
      r_grant_idx <= c_default_idx;
      r_hgrant    <= c_default_grant;
      r_beat_cnt  <= 5'd0;
      r_err_prev  <= 1'b0;
      r_hmaster   <= c_default_idx;
      r_hmastlock <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_grant_idx <= w_next_idx;
      r_hgrant    <= w_next_grant;
      r_err_prev  <= (hresp == HRESP_ERROR) && !hready;
      if (w_beat) begin
        r_beat_cnt <= w_beat_num;
      end
      // The address phase advances only on hready, so the owner ID follows
      // the grant one ready cycle late.
      if (hready) begin
        r_hmaster   <= r_grant_idx;
        r_hmastlock <= hlock[r_grant_idx];
      end
    end
  end

  assign hgrant    = r_hgrant;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_hmastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_bus_arbiter
// Purpose  : Directed self-checking bench for ahb_bus_arbiter: reset,
//            round-robin rotation, fixed bursts, wait states, locked
//            sequences, ERROR termination and reset mid-burst.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_bus_arbiter;

  localparam logic [1:0] c_t_idle   = 2'b00;
  localparam logic [1:0] c_t_nonseq = 2'b10;
  localparam logic [1:0] c_t_seq    = 2'b11;
  localparam logic [2:0] c_b_single = 3'b000;
  localparam logic [2:0] c_b_incr4  = 3'b011;
  localparam logic [2:0] c_b_wrap8  = 3'b100;
  localparam logic [2:0] c_b_incr8  = 3'b101;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [2:0] hbusreq;
  logic [2:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic       hresp;
  logic [2:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int checks = 0;
  int errors = 0;

  ahb_bus_arbiter dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of bus inputs, then sample just after the rising edge.
  task automatic step(input logic [1:0] t, input logic [2:0] b, input logic r, input logic e);
    htrans = t;
    hburst = b;
    hready = r;
    hresp  = e;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0;
    hbusreq = 3'b000;
    hlock   = 3'b000;
    htrans  = c_t_idle;
    hburst  = c_b_single;
    hready  = 1'b1;
    hresp   = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_hgrant", hgrant, 3'b001);
    chk("rst_hmaster", hmaster, 2'd0);
    chk("rst_hmastlock", hmastlock, 1'b0);
    hresetn = 1'b1;

    // Round-robin: SINGLE transfers, everyone requesting.
    hbusreq = 3'b111;
    step(c_t_nonseq, c_b_single, 1'b1, 1'b0);
    chk("rr1_hgrant", hgrant, 3'b010);
    chk("rr1_hmaster", hmaster, 2'd0);
    step(c_t_nonseq, c_b_single, 1'b1, 1'b0);
    chk("rr2_hgrant", hgrant, 3'b100);
    chk("rr2_hmaster", hmaster, 2'd1);
    step(c_t_nonseq, c_b_single, 1'b1, 1'b0);
    chk("rr3_hgrant", hgrant, 3'b001);
    chk("rr3_hmaster", hmaster, 2'd2);
    step(c_t_nonseq, c_b_single, 1'b1, 1'b0);
    chk("rr4_hgrant", hgrant, 3'b010);
    chk("rr4_hmaster", hmaster, 2'd0);

    // INCR4 owned by master 1; master 2 requests on beat 2.
    hbusreq = 3'b010;
    step(c_t_nonseq, c_b_incr4, 1'b1, 1'b0);
    chk("incr4_b1_hgrant", hgrant, 3'b010);
    hbusreq = 3'b110;
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    chk("incr4_b2_hgrant", hgrant, 3'b010);
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    chk("incr4_b3_hgrant", hgrant, 3'b010);
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    chk("incr4_b4_hgrant", hgrant, 3'b100);
    chk("incr4_b4_hmaster", hmaster, 2'd1);
    hbusreq = 3'b100;
    step(c_t_idle, c_b_incr4, 1'b1, 1'b0);
    chk("incr4_idle_hgrant", hgrant, 3'b100);
    chk("incr4_idle_hmaster", hmaster, 2'd2);

    // INCR8 owned by master 2 with three wait states on beat 5.
    hbusreq = 3'b101;
    step(c_t_nonseq, c_b_incr8, 1'b1, 1'b0);
    step(c_t_seq, c_b_incr8, 1'b1, 1'b0);
    step(c_t_seq, c_b_incr8, 1'b1, 1'b0);
    step(c_t_seq, c_b_incr8, 1'b1, 1'b0);
    chk("incr8_b4_hgrant", hgrant, 3'b100);
    repeat (3) step(c_t_seq, c_b_incr8, 1'b0, 1'b0);
    chk("incr8_wait_hgrant", hgrant, 3'b100);
    step(c_t_seq, c_b_incr8, 1'b1, 1'b0);
    chk("incr8_b5_hgrant", hgrant, 3'b100);
    step(c_t_seq, c_b_incr8, 1'b1, 1'b0);
    chk("incr8_b6_hgrant", hgrant, 3'b100);
    step(c_t_seq, c_b_incr8, 1'b1, 1'b0);
    chk("incr8_b7_hgrant", hgrant, 3'b100);
    step(c_t_seq, c_b_incr8, 1'b1, 1'b0);
    chk("incr8_b8_hgrant", hgrant, 3'b001);
    // hmaster must hold through a not-ready cycle after the grant change.
    step(c_t_idle, c_b_single, 1'b0, 1'b0);
    chk("hold_hmaster", hmaster, 2'd2);
    chk("hold_hgrant", hgrant, 3'b001);
    hbusreq = 3'b001;
    step(c_t_idle, c_b_single, 1'b1, 1'b0);
    chk("upd_hmaster", hmaster, 2'd0);
    chk("upd_hgrant", hgrant, 3'b001);

    // Locked sequence: master 2 holds hlock across two INCR4 bursts.
    hbusreq = 3'b100;
    step(c_t_idle, c_b_single, 1'b1, 1'b0);
    chk("lk_pre_hgrant", hgrant, 3'b100);
    hlock   = 3'b100;
    hbusreq = 3'b111;
    step(c_t_nonseq, c_b_incr4, 1'b1, 1'b0);
    chk("lk_a1_hmaster", hmaster, 2'd2);
    chk("lk_a1_hmastlock", hmastlock, 1'b1);
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    chk("lk_a4_hgrant", hgrant, 3'b100);
    chk("lk_a4_hmastlock", hmastlock, 1'b1);
    step(c_t_nonseq, c_b_incr4, 1'b1, 1'b0);
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    chk("lk_b3_hgrant", hgrant, 3'b100);
    chk("lk_b3_hmastlock", hmastlock, 1'b1);
    hlock = 3'b000;
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    chk("lk_b4_hgrant", hgrant, 3'b001);
    step(c_t_idle, c_b_single, 1'b1, 1'b0);
    chk("lk_end_hmastlock", hmastlock, 1'b0);
    chk("lk_end_hmaster", hmaster, 2'd0);
    chk("lk_end_hgrant", hgrant, 3'b010);

    // ERROR on WRAP8 beat 4 address phase, master 0 requesting.
    hbusreq = 3'b011;
    step(c_t_nonseq, c_b_wrap8, 1'b1, 1'b0);
    step(c_t_seq, c_b_wrap8, 1'b1, 1'b0);
    step(c_t_seq, c_b_wrap8, 1'b1, 1'b0);
    step(c_t_seq, c_b_wrap8, 1'b0, 1'b1);
    chk("err1_hgrant", hgrant, 3'b010);
    step(c_t_seq, c_b_wrap8, 1'b1, 1'b1);
    chk("err2_hgrant", hgrant, 3'b001);

    // Reset in the middle of a locked INCR4 owned by master 1.
    hbusreq = 3'b010;
    hlock   = 3'b010;
    step(c_t_idle, c_b_single, 1'b1, 1'b0);
    step(c_t_nonseq, c_b_incr4, 1'b1, 1'b0);
    step(c_t_seq, c_b_incr4, 1'b1, 1'b0);
    chk("mid_hgrant", hgrant, 3'b010);
    chk("mid_hmaster", hmaster, 2'd1);
    chk("mid_hmastlock", hmastlock, 1'b1);
    #2;
    hresetn = 1'b0;
    #1;
    chk("arst_hgrant", hgrant, 3'b001);
    chk("arst_hmaster", hmaster, 2'd0);
    chk("arst_hmastlock", hmastlock, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
